sdram_access_scheduler: RTL
===========================

// Module: sdram_access_scheduler
// PURPOSE
//  Sits between the SDRAM driver and its users: schedules periodic auto-refresh and
//  round-robin shares the SDRAM between two requesters (0: sample logger, 1: host port).
//  Emits one command at a time (read/write burst or refresh) to the driver over a
//  valid/accept handshake, then holds off new work until the driver signals done.
// PARAMETERS
//  P_REFRESH_INTERVAL  390  clocks between refresh ticks (7.8us @ 50MHz)
//  P_MAX_PENDING       3    max queued refreshes before o_RefreshMissed sets (1..3)
//  P_ADDR_W            24   request address width (bank+row+col)
//  P_LEN_W             9    burst length field width, encodes beats-1
// PORTS
//  i_Clock        in   1         system clock, all logic on rising edge
//  i_nReset       in   1         async active-low reset
//  i_InitDone     in   1         driver finished power-up/mode-set sequence
//  i_Req          in   2         request per requester, level, held until granted
//  i_ReqWrite     in   2         1=write burst, 0=read burst, per requester
//  i_ReqAddr0     in   P_ADDR_W  requester 0 start address
//  i_ReqAddr1     in   P_ADDR_W  requester 1 start address
//  i_ReqLen0      in   P_LEN_W   requester 0 beats-1
//  i_ReqLen1      in   P_LEN_W   requester 1 beats-1
//  o_Grant        out  2         one-hot owner of current transaction
//  o_CmdValid     out  1         command fields valid to driver
//  o_CmdKind      out  2         00 read, 01 write, 10 refresh, 11 unused
//  o_CmdAddr      out  P_ADDR_W  burst address (0 for refresh)
//  o_CmdLen       out  P_LEN_W   burst beats-1 (0 for refresh)
//  i_CmdAccept    in   1         driver took command this cycle
//  i_CmdDone      in   1         driver finished command (incl. tRC/tWR), 1-cycle pulse
//  o_RefreshMissed out 1         sticky: refresh backlog overflowed
// BEHAVIOUR
//  Reset: all outputs 0, state INIT_WAIT, refresh timer/pending/RR pointer cleared
//   (pointer favours requester 0). Reset mid-transaction abandons it immediately.
//  States: INIT_WAIT -> IDLE on i_InitDone=1 (sampled only in INIT_WAIT).
//   IDLE: pick in priority: refresh if pending>0; else requester per round-robin;
//    -> ISSUE next cycle with registered o_CmdValid=1 and fields latched (latency 1).
//   ISSUE: fields/o_Grant stable while o_CmdValid=1; on i_CmdAccept -> BUSY,
//    o_CmdValid=0 next cycle. Accept+Done same cycle -> IDLE directly.
//   BUSY: on i_CmdDone -> IDLE; o_Grant cleared entering IDLE.
//  Grant is never preempted; refresh waits for the transaction boundary.
//  Round-robin: both requesting -> grant the one not served last; single requester
//   always granted; pointer updates only on data grants, not refresh.
//  Refresh timer: runs only after leaving INIT_WAIT; counts 0..P_REFRESH_INTERVAL-1,
//   wraps, and on wrap increments pending. Pending decrements on refresh accept.
//   Tick and decrement same cycle -> pending unchanged.
//   Tick with pending==P_MAX_PENDING -> pending stays, o_RefreshMissed=1 until reset.
//  i_Req dropped before grant is legal (request withdrawn); after grant it is ignored.
//  i_CmdDone outside BUSY/ISSUE is ignored. o_CmdKind=11 never driven.
// CONFIGURATION
//  SDRAM_SCHED_STATS_EN defined: adds outputs o_GrantCount0, o_GrantCount1,
//   o_RefreshCount (16b each, saturating at 16'hFFFF, cleared by reset), incremented
//   on each accepted command of that type. Undefined: ports and counters absent,
//   all other behaviour identical.
// TESTING
//  Reset, hold i_InitDone=0 for 500 clk with i_Req=2'b11 -> o_CmdValid stays 0.
//  InitDone=1, i_Req=2'b01 write, addr 24'h00_1234, len 9'd7 -> next clk CmdValid=1,
//   Kind=01, Addr=24'h001234, Len=7, Grant=01; held until Accept; idle after Done.
//  i_Req=2'b11 continuously, Accept+Done immediate -> grants alternate 01,10,01,10.
//  No requests, 1200 clk -> 3 refresh cmds (Kind=10) at timer wraps ~390 clk apart.
//  Hold driver in BUSY (no Done) 4*P_REFRESH_INTERVAL -> o_RefreshMissed=1; after Done,
//   3 back-to-back refreshes before any data grant.
//  Assert i_nReset low during ISSUE -> all outputs 0 same cycle; restart in INIT_WAIT.

Source files
------------

// File: rtl/sdram_access_scheduler.sv
// sdram_access_scheduler
//   Arbitrates SDRAM access between a sample logger (requester 0) and a host
//   port (requester 1), and injects periodic auto-refresh commands. Only one
//   command is outstanding at a time: it is offered to the driver, accepted,
//   and the scheduler then waits for the driver's completion pulse.
//
//   Handshake: o_CmdValid is registered and, while high, o_CmdKind/o_CmdAddr/
//   o_CmdLen/o_Grant are held stable. The command transfers on the first
//   rising edge where o_CmdValid=1 and i_CmdAccept=1. i_CmdDone is a one-cycle
//   completion pulse; it may coincide with the accept, otherwise it is only
//   honoured after the accept. Done pulses while nothing is outstanding are
//   ignored.
//
//   Optional build macro: SDRAM_SCHED_STATS_EN adds saturating 16-bit
//   accepted-command counters (o_GrantCount0, o_GrantCount1, o_RefreshCount).
//   o_DbgState exposes the scheduler state (0 init-wait, 1 idle, 2 issue,
//   3 busy).
`timescale 1ns/1ps
module sdram_access_scheduler #(
  parameter int P_REFRESH_INTERVAL = 390,
  parameter int P_MAX_PENDING      = 3,
  parameter int P_ADDR_W           = 24,
  parameter int P_LEN_W            = 9
) (
  input  logic                i_Clock,
  input  logic                i_nReset,
  input  logic                i_InitDone,
  input  logic [1:0]          i_Req,
  input  logic [1:0]          i_ReqWrite,
  input  logic [P_ADDR_W-1:0] i_ReqAddr0,
  input  logic [P_ADDR_W-1:0] i_ReqAddr1,
  input  logic [P_LEN_W-1:0]  i_ReqLen0,
  input  logic [P_LEN_W-1:0]  i_ReqLen1,
  output logic [1:0]          o_Grant,
  output logic                o_CmdValid,
  output logic [1:0]          o_CmdKind,
  output logic [P_ADDR_W-1:0] o_CmdAddr,
  output logic [P_LEN_W-1:0]  o_CmdLen,
  input  logic                i_CmdAccept,
  input  logic                i_CmdDone,
  output logic                o_RefreshMissed,
`ifdef SDRAM_SCHED_STATS_EN
  output logic [15:0]         o_GrantCount0,
  output logic [15:0]         o_GrantCount1,
  output logic [15:0]         o_RefreshCount,
`endif
  output logic [1:0]          o_DbgState
);

  localparam int LP_TMR_W = (P_REFRESH_INTERVAL > 1) ? $clog2(P_REFRESH_INTERVAL) : 1;
  localparam logic [LP_TMR_W-1:0] LP_TMR_LAST = LP_TMR_W'(P_REFRESH_INTERVAL - 1);
  localparam logic [1:0] LP_MAX_PEND = 2'(P_MAX_PENDING);

  localparam logic [1:0] LP_KIND_READ  = 2'b00;
  localparam logic [1:0] LP_KIND_WRITE = 2'b01;
  localparam logic [1:0] LP_KIND_REF   = 2'b10;

  typedef enum logic [1:0] {
    S_INIT_WAIT = 2'd0,
    S_IDLE      = 2'd1,
    S_ISSUE     = 2'd2,
    S_BUSY      = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_cmd_valid;
  logic [1:0]            r_kind;
  logic [P_ADDR_W-1:0]   r_addr;
  logic [P_LEN_W-1:0]    r_len;
  logic [1:0]            r_grant;
  logic                  r_rr_favour1;
  logic [LP_TMR_W-1:0]   r_timer;
  logic [1:0]            r_pending;
  logic                  r_missed;

  logic                  w_run;
  logic                  w_tick;
  logic                  w_accept;
  logic                  w_ref_take;
  logic                  w_pick1;
  logic                  w_sel_write;
  logic [P_ADDR_W-1:0]   w_sel_addr;
  logic [P_LEN_W-1:0]    w_sel_len;

  assign w_run      = (r_state != S_INIT_WAIT);
  assign w_tick     = w_run && (r_timer == LP_TMR_LAST);
  assign w_accept   = (r_state == S_ISSUE) && i_CmdAccept;
  assign w_ref_take = w_accept && (r_kind == LP_KIND_REF);

  // Requester 1 wins when it is the only one asking, or when both ask and it is its turn.
  assign w_pick1     = i_Req[1] && (!i_Req[0] || r_rr_favour1);
  assign w_sel_write = w_pick1 ? i_ReqWrite[1] : i_ReqWrite[0];
  assign w_sel_addr  = w_pick1 ? i_ReqAddr1 : i_ReqAddr0;
  assign w_sel_len   = w_pick1 ? i_ReqLen1 : i_ReqLen0;

  // Refresh interval timer: free-runs 0..P_REFRESH_INTERVAL-1 once init is done.
  always_ff @(posedge i_Clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_timer <= '0;
    end else if (!w_run || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Refresh backlog: ticks add, accepted refreshes remove; overflow is sticky.
  always_ff @(posedge i_Clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_pending <= '0;
      r_missed  <= 1'b0;
    end else if (w_tick && !w_ref_take) begin
      if (r_pending == LP_MAX_PEND) begin
        r_missed <= 1'b1;
      end else begin
        r_pending <= r_pending + 1'b1;
      end
    end else if (!w_tick && w_ref_take) begin
      r_pending <= r_pending - 1'b1;
    end
  end

  // Scheduler FSM with registered command outputs and round-robin pointer.
  always_ff @(posedge i_Clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state      <= S_INIT_WAIT;
      r_cmd_valid  <= 1'b0;
      r_kind       <= LP_KIND_READ;
      r_addr       <= '0;
      r_len        <= '0;
      r_grant      <= 2'b00;
      r_rr_favour1 <= 1'b0;
    end else begin
      case (r_state)
        S_INIT_WAIT: begin
          if (i_InitDone) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (r_pending != 2'd0) begin
            r_cmd_valid <= 1'b1;
            r_kind      <= LP_KIND_REF;
            r_addr      <= '0;
            r_len       <= '0;
            r_grant     <= 2'b00;
            r_state     <= S_ISSUE;
          end else if (|i_Req) begin
            r_cmd_valid  <= 1'b1;
            r_kind       <= w_sel_write ? LP_KIND_WRITE : LP_KIND_READ;
            r_addr       <= w_sel_addr;
            r_len        <= w_sel_len;
            r_grant      <= w_pick1 ? 2'b10 : 2'b01;
            r_rr_favour1 <= !w_pick1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_CmdAccept) begin
            r_cmd_valid <= 1'b0;
            if (i_CmdDone) begin
              r_grant <= 2'b00;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (i_CmdDone) begin
            r_grant <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_INIT_WAIT;
        end
      endcase
    end
  end

`ifdef SDRAM_SCHED_STATS_EN
  logic [15:0] r_cnt_g0;
  logic [15:0] r_cnt_g1;
  logic [15:0] r_cnt_ref;

  // Saturating counters of accepted commands by type/owner.
  always_ff @(posedge i_Clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_cnt_g0  <= '0;
      r_cnt_g1  <= '0;
      r_cnt_ref <= '0;
    end else if (w_accept) begin
      if (r_kind == LP_KIND_REF) begin
        if (r_cnt_ref != 16'hFFFF) r_cnt_ref <= r_cnt_ref + 1'b1;
      end else if (r_grant[1]) begin
        if (r_cnt_g1 != 16'hFFFF) r_cnt_g1 <= r_cnt_g1 + 1'b1;
      end else begin
        if (r_cnt_g0 != 16'hFFFF) r_cnt_g0 <= r_cnt_g0 + 1'b1;
      end
    end
  end

  assign o_GrantCount0  = r_cnt_g0;
  assign o_GrantCount1  = r_cnt_g1;
  assign o_RefreshCount = r_cnt_ref;
`endif

  assign o_Grant         = r_grant;
  assign o_CmdValid      = r_cmd_valid;
  assign o_CmdKind       = r_kind;
  assign o_CmdAddr       = r_addr;
  assign o_CmdLen        = r_len;
  assign o_RefreshMissed = r_missed;
  assign o_DbgState      = r_state;

endmodule
